// File: rtl/raptor64_rx_latch_if.sv
// rtl/raptor64_rx_latch_if.sv - register-read to execute latch port bundle
// master drives decode/hazard inputs; slave is the latch itself.
interface raptor64_rx_latch_if;
  logic        advanceX;
  logic        flush;
  logic        dIRvalid;
  logic [8:0]  dRa;
  logic [8:0]  dRb;
  logic [8:0]  dRc;
  logic        dRaUsed;
  logic        dRbUsed;
  logic        dRcUsed;
  logic [63:0] dpc;
  logic [63:0] nxt_a;
  logic [63:0] nxt_b;
  logic [63:0] nxt_c;
  logic [8:0]  xRt;
  logic [8:0]  m1Rt;
  logic        xIsLoad;
  logic        m1IsLoad;
  logic        advanceR;
  logic        xIRvalid;
  logic [63:0] xA;
  logic [63:0] xB;
  logic [63:0] xC;
  logic [63:0] xpc;
  logic [31:0] stall_cnt;

  modport master (
    output advanceX, flush, dIRvalid, dRa, dRb, dRc, dRaUsed, dRbUsed, dRcUsed,
           dpc, nxt_a, nxt_b, nxt_c, xRt, m1Rt, xIsLoad, m1IsLoad,
    input  advanceR, xIRvalid, xA, xB, xC, xpc, stall_cnt
  );

  modport slave (
    input  advanceX, flush, dIRvalid, dRa, dRb, dRc, dRaUsed, dRbUsed, dRcUsed,
           dpc, nxt_a, nxt_b, nxt_c, xRt, m1Rt, xIsLoad, m1IsLoad,
    output advanceR, xIRvalid, xA, xB, xC, xpc, stall_cnt
  );
endinterface

// File: rtl/raptor64_rx_latch.sv
// rtl/raptor64_rx_latch.sv - Raptor64 R->X latch with load-use bubble insertion
// Optional bubble statistics counter: define RAPTOR64_RX_STALLCNT_EN.
module raptor64_rx_latch #(
  parameter int XLOAD_BUBBLES  = 2,
  parameter int M1LOAD_BUBBLES = 1,
  parameter int CNTW           = 2
) (
  input logic              clk,
  input logic              rst,
  raptor64_rx_latch_if.slave rx
);

  logic [CNTW-1:0] cnt;
  logic            valid_q;
  logic [63:0]     a_q, b_q, c_q, pc_q;

  // Registers 0 and 29 are constant/PC sources; the match uses all 9 bits.
  function automatic logic live_src(input logic v, input logic used, input logic [8:0] r);
    return v & used & (r[4:0] != 5'd0) & (r[4:0] != 5'd29);
  endfunction

  logic live_a, live_b, live_c;
  logic any_hx, any_hm, hz;

  assign live_a = live_src(rx.dIRvalid, rx.dRaUsed, rx.dRa);
  assign live_b = live_src(rx.dIRvalid, rx.dRbUsed, rx.dRb);
  assign live_c = live_src(rx.dIRvalid, rx.dRcUsed, rx.dRc);

  assign any_hx = rx.xIsLoad & ((live_a & (rx.dRa == rx.xRt)) |
                                (live_b & (rx.dRb == rx.xRt)) |
                                (live_c & (rx.dRc == rx.xRt)));
  assign any_hm = rx.m1IsLoad & ((live_a & (rx.dRa == rx.m1Rt)) |
                                 (live_b & (rx.dRb == rx.m1Rt)) |
                                 (live_c & (rx.dRc == rx.m1Rt)));
  assign hz = any_hx | any_hm;

  assign rx.advanceR = rx.advanceX & ~rst & (cnt == '0) & ~hz;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      pc_q    <= '0;
    end else if (rx.flush) begin
      cnt     <= '0;
      valid_q <= 1'b0;
    end else if (rx.advanceX) begin
      if (cnt != '0) begin
        cnt     <= cnt - 1'b1;
        valid_q <= 1'b0;
      end else if (hz) begin
        // X-stage load data arrives later, so it wins when both stages match.
        cnt     <= any_hx ? CNTW'(XLOAD_BUBBLES - 1) : CNTW'(M1LOAD_BUBBLES - 1);
        valid_q <= 1'b0;
      end else begin
        a_q     <= rx.nxt_a;
        b_q     <= rx.nxt_b;
        c_q     <= rx.nxt_c;
        pc_q    <= rx.dpc;
        valid_q <= rx.dIRvalid;
      end
    end
  end

  assign rx.xIRvalid = valid_q;
  assign rx.xA       = a_q;
  assign rx.xB       = b_q;
  assign rx.xC       = c_q;
  assign rx.xpc      = pc_q;

`ifdef RAPTOR64_RX_STALLCNT_EN
  logic        bubble;
  logic [31:0] stall_q;

  assign bubble = rx.advanceX & ~rx.flush & ((cnt != '0) | hz);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (bubble) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign rx.stall_cnt = stall_q;
`else
  assign rx.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_raptor64_rx_latch.sv
// tb/tb_raptor64_rx_latch.sv - directed table and sequence checks for raptor64_rx_latch
module tb_raptor64_rx_latch;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_stall = 32'd0;

`ifdef RAPTOR64_RX_STALLCNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  raptor64_rx_latch_if rx();

  raptor64_rx_latch #(.XLOAD_BUBBLES(2), .M1LOAD_BUBBLES(1), .CNTW(2)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        adv;
    logic        dv;
    logic [8:0]  ra, rb, rc;
    logic [2:0]  used;
    logic [8:0]  xrt, m1rt;
    logic        xl, m1l;
    logic [63:0] a, b, c, pc;
    logic        e_adv, e_v;
    logic [63:0] e_a, e_b, e_c, e_pc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rx.advanceX = 1'b1; rx.flush = 1'b0; rx.dIRvalid = 1'b1;
    rx.dRa = 9'd1; rx.dRb = 9'd2; rx.dRc = 9'd3;
    rx.dRaUsed = 1'b1; rx.dRbUsed = 1'b1; rx.dRcUsed = 1'b1;
    rx.xRt = 9'd20; rx.m1Rt = 9'd21; rx.xIsLoad = 1'b0; rx.m1IsLoad = 1'b0;
  endtask

  task automatic ops(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] pc);
    rx.nxt_a = a; rx.nxt_b = b; rx.nxt_c = c; rx.dpc = pc;
  endtask

  initial begin
    vecs[0] = '{1, 1, 9'd5,   9'd1, 9'd2,     3'b111, 9'd20,    9'd21,    0, 0, 64'h1234, 64'hB0, 64'hC0, 64'h100, 1, 1, 64'h1234, 64'hB0, 64'hC0, 64'h100};
    vecs[1] = '{1, 1, 9'd0,   9'd1, 9'd2,     3'b111, 9'd0,     9'd21,    1, 0, 64'h11,   64'h12, 64'h13, 64'h104, 1, 1, 64'h11,   64'h12, 64'h13, 64'h104};
    vecs[2] = '{1, 1, 9'd29,  9'd1, 9'd2,     3'b111, 9'd29,    9'd21,    1, 0, 64'h21,   64'h22, 64'h23, 64'h108, 1, 1, 64'h21,   64'h22, 64'h23, 64'h108};
    vecs[3] = '{1, 1, 9'd12,  9'd1, 9'd2,     3'b110, 9'd12,    9'd21,    1, 0, 64'h31,   64'h32, 64'h33, 64'h10c, 1, 1, 64'h31,   64'h32, 64'h33, 64'h10c};
    vecs[4] = '{1, 0, 9'd12,  9'd1, 9'd2,     3'b111, 9'd12,    9'd21,    1, 0, 64'h41,   64'h42, 64'h43, 64'h110, 1, 0, 64'h41,   64'h42, 64'h43, 64'h110};
    vecs[5] = '{1, 1, 9'd5,   9'd1, 9'd2,     3'b111, 9'h105,   9'd21,    1, 0, 64'h51,   64'h52, 64'h53, 64'h114, 1, 1, 64'h51,   64'h52, 64'h53, 64'h114};
    vecs[6] = '{0, 1, 9'd5,   9'd1, 9'd2,     3'b111, 9'd20,    9'd21,    0, 0, 64'h61,   64'h62, 64'h63, 64'h118, 0, 1, 64'h51,   64'h52, 64'h53, 64'h114};
    vecs[7] = '{1, 1, 9'd1,   9'd2, 9'h1DD,   3'b111, 9'd20,    9'h1DD,   0, 1, 64'h71,   64'h72, 64'h73, 64'h11c, 1, 1, 64'h71,   64'h72, 64'h73, 64'h11c};

    // Reset held two cycles with advanceX high and live operands.
    idle();
    ops(64'hAAAA, 64'hBBBB, 64'hCCCC, 64'hDDDD);
    rst = 1'b1;
    #1;
    chk("rst_advanceR", {63'd0, rx.advanceR}, 64'd0);
    step();
    step();
    chk("rst_xIRvalid", {63'd0, rx.xIRvalid}, 64'd0);
    chk("rst_xA", rx.xA, 64'd0);
    chk("rst_xpc", rx.xpc, 64'd0);
    chk("rst_advanceR_held", {63'd0, rx.advanceR}, 64'd0);
    chk("rst_stall_cnt", {32'd0, rx.stall_cnt}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rx.advanceX = vecs[i].adv; rx.flush = 1'b0; rx.dIRvalid = vecs[i].dv;
      rx.dRa = vecs[i].ra; rx.dRb = vecs[i].rb; rx.dRc = vecs[i].rc;
      rx.dRaUsed = vecs[i].used[0]; rx.dRbUsed = vecs[i].used[1]; rx.dRcUsed = vecs[i].used[2];
      rx.xRt = vecs[i].xrt; rx.m1Rt = vecs[i].m1rt; rx.xIsLoad = vecs[i].xl; rx.m1IsLoad = vecs[i].m1l;
      ops(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].pc);
      #1;
      chk($sformatf("vec%0d_advanceR", i), {63'd0, rx.advanceR}, {63'd0, vecs[i].e_adv});
      step();
      chk($sformatf("vec%0d_xIRvalid", i), {63'd0, rx.xIRvalid}, {63'd0, vecs[i].e_v});
      chk($sformatf("vec%0d_xA", i), rx.xA, vecs[i].e_a);
      chk($sformatf("vec%0d_xB", i), rx.xB, vecs[i].e_b);
      chk($sformatf("vec%0d_xC", i), rx.xC, vecs[i].e_c);
      chk($sformatf("vec%0d_xpc", i), rx.xpc, vecs[i].e_pc);
    end
    // State now: xIRvalid=1, xA..xpc = 71/72/73/11c.

    // X load-use: two bubbles, with an advanceX=0 hold between them.
    idle();
    rx.xIsLoad = 1'b1; rx.xRt = 9'd7; rx.dRb = 9'd7;
    ops(64'h81, 64'hBEEF, 64'h83, 64'h120);
    #1;
    chk("xl_advanceR_c1", {63'd0, rx.advanceR}, 64'd0);
    step();
    if (STALL_EN) exp_stall++;
    chk("xl_xIRvalid_b1", {63'd0, rx.xIRvalid}, 64'd0);
    chk("xl_xB_hold_b1", rx.xB, 64'h72);
    rx.xIsLoad = 1'b0;
    rx.advanceX = 1'b0;
    #1;
    chk("xl_advanceR_hold", {63'd0, rx.advanceR}, 64'd0);
    step();
    rx.advanceX = 1'b1;
    #1;
    chk("xl_advanceR_c2", {63'd0, rx.advanceR}, 64'd0);
    step();
    if (STALL_EN) exp_stall++;
    chk("xl_xIRvalid_b2", {63'd0, rx.xIRvalid}, 64'd0);
    chk("xl_advanceR_c3", {63'd0, rx.advanceR}, 64'd1);
    step();
    chk("xl_xIRvalid_rel", {63'd0, rx.xIRvalid}, 64'd1);
    chk("xl_xB_rel", rx.xB, 64'hBEEF);
    chk("xl_xpc_rel", rx.xpc, 64'h120);
    chk("xl_stall_cnt", {32'd0, rx.stall_cnt}, {32'd0, exp_stall});

    // M1 load-use: advanceX=0 before and after the single bubble.
    idle();
    rx.m1IsLoad = 1'b1; rx.m1Rt = 9'd9; rx.dRc = 9'd9;
    ops(64'h91, 64'h92, 64'hCAFE, 64'h124);
    rx.advanceX = 1'b0;
    step();
    chk("m1_pre_xIRvalid_hold", {63'd0, rx.xIRvalid}, 64'd1);
    rx.advanceX = 1'b1;
    #1;
    chk("m1_advanceR_c1", {63'd0, rx.advanceR}, 64'd0);
    step();
    if (STALL_EN) exp_stall++;
    chk("m1_xIRvalid_b1", {63'd0, rx.xIRvalid}, 64'd0);
    rx.m1IsLoad = 1'b0;
    rx.advanceX = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("m1_hold%0d_advanceR", k), {63'd0, rx.advanceR}, 64'd0);
      step();
      chk($sformatf("m1_hold%0d_xIRvalid", k), {63'd0, rx.xIRvalid}, 64'd0);
    end
    rx.advanceX = 1'b1;
    #1;
    chk("m1_advanceR_rel", {63'd0, rx.advanceR}, 64'd1);
    step();
    chk("m1_xC_rel", rx.xC, 64'hCAFE);
    chk("m1_xIRvalid_rel", {63'd0, rx.xIRvalid}, 64'd1);
    chk("m1_stall_cnt", {32'd0, rx.stall_cnt}, {32'd0, exp_stall});

    // X and M1 both match: X count (two bubbles) must win.
    idle();
    rx.xIsLoad = 1'b1; rx.xRt = 9'd4; rx.dRa = 9'd4;
    rx.m1IsLoad = 1'b1; rx.m1Rt = 9'd6; rx.dRb = 9'd6;
    ops(64'hA1, 64'hA2, 64'hA3, 64'h128);
    step();
    if (STALL_EN) exp_stall++;
    rx.xIsLoad = 1'b0; rx.m1IsLoad = 1'b0;
    #1;
    chk("both_advanceR_c2", {63'd0, rx.advanceR}, 64'd0);
    step();
    if (STALL_EN) exp_stall++;
    chk("both_advanceR_c3", {63'd0, rx.advanceR}, 64'd1);
    step();
    chk("both_xA_rel", rx.xA, 64'hA1);

    // Flush on the first bubble cycle clears the countdown.
    idle();
    rx.xIsLoad = 1'b1; rx.xRt = 9'd7; rx.dRb = 9'd7;
    ops(64'hF1, 64'hF2, 64'hF3, 64'h12c);
    step();
    if (STALL_EN) exp_stall++;
    rx.xIsLoad = 1'b0;
    rx.flush = 1'b1;
    step();
    chk("fl_xIRvalid", {63'd0, rx.xIRvalid}, 64'd0);
    chk("fl_xB_hold", rx.xB, 64'hA2);
    chk("fl_stall_cnt", {32'd0, rx.stall_cnt}, {32'd0, exp_stall});
    rx.flush = 1'b0;
    #1;
    chk("fl_advanceR_after", {63'd0, rx.advanceR}, 64'd1);
    step();
    chk("fl_xB_rel", rx.xB, 64'hF2);
    chk("fl_xIRvalid_rel", {63'd0, rx.xIRvalid}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
